// File: rtl/rggen_apb_bridge.sv
// rggen_apb_bridge: APB slave to register-bus bridge.
// An APB access is captured in IDLE, presented on the register bus in BUSY
// until bus_ready, and answered with a single-cycle pready in ACK.
// Optional feature macro: RGGEN_APB_BRIDGE_TIMEOUT_EN enables a BUSY-state
// timeout of TIMEOUT_CYCLES cycles that answers with pslverr=1.
module rggen_apb_bridge #(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // APB slave
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDRESS_WIDTH-1:0]  paddr,
  input  logic [2:0]                pprot,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pslverr,
  // register bus master
  output logic                      bus_valid,
  output logic                      bus_write,
  output logic [ADDRESS_WIDTH-1:0]  bus_address,
  output logic [2:0]                bus_prot,
  output logic [DATA_WIDTH-1:0]     bus_write_data,
  output logic [DATA_WIDTH/8-1:0]   bus_strobe,
  input  logic                      bus_ready,
  input  logic [1:0]                bus_status,
  input  logic [DATA_WIDTH-1:0]     bus_read_data
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]               prot_q, prot_d;
  logic                     write_q, write_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]    strb_q, strb_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [1:0]               status_q, status_d;
  logic                     abort_q, abort_d;

  logic                     capture;
  logic                     complete;
  logic                     timeout;

  // penable is not needed: a transfer is accepted on psel alone.
  logic unused_bits;
  assign unused_bits = ^{penable, status_q[0]};

  assign capture  = (state_q == IDLE) && psel;
  assign complete = (state_q == BUSY) && bus_ready;

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
  logic [15:0] count_q, count_d;

  // Wait counter: cleared on entry to BUSY, counts BUSY cycles without bus_ready.
  always_comb begin
    count_d = count_q;
    if (capture) begin
      count_d = '0;
    end else if ((state_q == BUSY) && !bus_ready) begin
      count_d = count_q + 16'd1;
    end
  end

  // bus_ready in the expiring cycle wins, so timeout requires bus_ready=0.
  assign timeout = (state_q == BUSY) && !bus_ready &&
                   ((count_q + 16'd1) == 16'(TIMEOUT_CYCLES));

  // Wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
`else
  localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an access abandoned by the master returns straight to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (psel) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (complete || timeout) begin
          state_d = (abort_q || !psel) ? IDLE : ACK;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture, abort tracking and response capture.
  always_comb begin
    addr_d   = addr_q;
    prot_d   = prot_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    abort_d  = abort_q;
    if (capture) begin
      addr_d  = paddr;
      prot_d  = pprot;
      write_d = pwrite;
      wdata_d = pwdata;
      strb_d  = pwrite ? pstrb : '1;
      abort_d = 1'b0;
    end
    if ((state_q == BUSY) && !psel) begin
      abort_d = 1'b1;
    end
    if (complete) begin
      rdata_d  = bus_read_data;
      status_d = bus_status;
    end else if (timeout) begin
      rdata_d  = '0;
      status_d = 2'b10;
    end
  end

  // Request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      prot_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
      status_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      prot_q   <= prot_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      abort_q  <= abort_d;
    end
  end

  // Output decode: bus request from BUSY, APB response only in ACK.
  always_comb begin
    bus_valid      = (state_q == BUSY);
    bus_write      = write_q;
    bus_address    = addr_q;
    bus_prot       = prot_q;
    bus_write_data = wdata_q;
    bus_strobe     = strb_q;
    pready         = (state_q == ACK);
    pslverr        = pready && status_q[1];
    prdata         = (pready && !write_q && !status_q[1]) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// tb_rggen_apb_bridge: randomized self-checking bench for rggen_apb_bridge.
// Build with RGGEN_APB_BRIDGE_TIMEOUT_EN defined to exercise the timeout.
`timescale 1ns/1ps
module tb_rggen_apb_bridge;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int          TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [2:0]    pprot;
  logic [DW-1:0] pwdata;
  logic [SW-1:0] pstrb;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;
  logic          bus_valid, bus_write;
  logic [AW-1:0] bus_address;
  logic [2:0]    bus_prot;
  logic [DW-1:0] bus_write_data;
  logic [SW-1:0] bus_strobe;
  logic          bus_ready;
  logic [1:0]    bus_status;
  logic [DW-1:0] bus_read_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rggen_apb_bridge #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .psel          (psel),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pprot         (pprot),
    .pwdata        (pwdata),
    .pstrb         (pstrb),
    .pready        (pready),
    .prdata        (prdata),
    .pslverr       (pslverr),
    .bus_valid     (bus_valid),
    .bus_write     (bus_write),
    .bus_address   (bus_address),
    .bus_prot      (bus_prot),
    .bus_write_data(bus_write_data),
    .bus_strobe    (bus_strobe),
    .bus_ready     (bus_ready),
    .bus_status    (bus_status),
    .bus_read_data (bus_read_data)
  );

  // Expected outcome of one access, from the bridge's external rules.
  typedef struct {
    int            valid_cycles;
    int            ack_k;
    logic          slverr;
    logic [DW-1:0] prdata;
    logic [SW-1:0] strobe;
    int            handshakes;
  } resp_t;

  // What the bench saw during one access.
  typedef struct {
    int            valid_cycles;
    int            ready_cycles;
    int            ack_k;
    int            handshakes;
    int            first_valid_cyc;
    int            ack_cyc;
    logic [AW-1:0] addr;
    logic          wr;
    logic [2:0]    prot;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strobe;
    bit            stable;
    bit            quiet_ok;
    logic [DW-1:0] prdata;
    logic          slverr;
    logic          pready_after;
  } obs_t;

  typedef struct {
    bit            wr;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [SW-1:0] st;
    logic [1:0]    sts;
    logic [DW-1:0] rd;
    int            w;
  } vec_t;

  // wait_n: number of BUSY cycles with bus_ready=0 before the slave answers.
  function automatic resp_t model(bit wr, logic [SW-1:0] st, int wait_n,
                                  logic [1:0] sts, logic [DW-1:0] rd);
    resp_t r;
    bit timed_out;
    timed_out = 1'b0;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
    timed_out = (wait_n >= TO);
`endif
    r.strobe = wr ? st : 4'hF;
    if (timed_out) begin
      r.valid_cycles = TO;
      r.ack_k        = TO;
      r.slverr       = 1'b1;
      r.prdata       = '0;
      r.handshakes   = 0;
    end else begin
      r.valid_cycles = wait_n + 1;
      r.ack_k        = wait_n + 1;
      r.slverr       = sts[1];
      r.prdata       = (wr || sts[1]) ? '0 : rd;
      r.handshakes   = 1;
    end
    return r;
  endfunction

  // APB master plus register-bus slave for one access; records observations only.
  task automatic apb_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [SW-1:0] st, input logic [2:0] pr, input int wait_n,
                          input logic [1:0] sts, input logic [DW-1:0] rd,
                          input bit drop_psel, input bit keep_psel, output obs_t o);
    o.valid_cycles = 0;  o.ready_cycles = 0; o.ack_k = -1; o.handshakes = 0;
    o.first_valid_cyc = -1; o.ack_cyc = -1; o.addr = '0; o.wr = 1'b0; o.prot = '0;
    o.wdata = '0; o.strobe = '0; o.stable = 1'b1; o.quiet_ok = 1'b1;
    o.prdata = '0; o.slverr = 1'b0; o.pready_after = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    pstrb = st; pprot = pr; bus_ready = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      if (drop_psel && k == 0) begin psel = 1'b0; penable = 1'b0; end
      // Request inputs change after capture; the bus side must not follow them.
      paddr = AW'($urandom); pwdata = $urandom; pstrb = SW'($urandom);
      pprot = 3'($urandom); pwrite = 1'($urandom);
      bus_ready     = (k == wait_n);
      bus_status    = (k == wait_n) ? sts : 2'($urandom);
      bus_read_data = (k == wait_n) ? rd : $urandom;
      @(negedge clk);
      if (bus_valid) begin
        if (o.valid_cycles == 0) begin
          o.addr = bus_address; o.wr = bus_write; o.prot = bus_prot;
          o.wdata = bus_write_data; o.strobe = bus_strobe; o.first_valid_cyc = cyc;
        end else if ({bus_address, bus_write, bus_prot, bus_write_data, bus_strobe} !==
                     {o.addr, o.wr, o.prot, o.wdata, o.strobe}) begin
          o.stable = 1'b0;
        end
        o.valid_cycles++;
        if (bus_ready) o.handshakes++;
      end
      if (!pready && (pslverr !== 1'b0 || prdata !== '0)) o.quiet_ok = 1'b0;
      if (pready) begin
        o.ready_cycles++;
        o.ack_k = k; o.ack_cyc = cyc; o.prdata = prdata; o.slverr = pslverr;
        if (!keep_psel) begin
          @(posedge clk); #1;
          psel = 1'b0; penable = 1'b0; bus_ready = 1'b0;
          @(negedge clk);
          o.pready_after = pready;
        end
        break;
      end
    end
    if (o.ack_k < 0) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; bus_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'hA5A5; pprot = 3'h7;
    pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    bus_ready = 1'b1; bus_status = 2'b11; bus_read_data = 32'h55AA55AA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({pready, pslverr, prdata, bus_valid, bus_write, bus_address, bus_prot,
         bus_write_data, bus_strobe} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got pready=%b pslverr=%b prdata=%h valid=%b write=%b addr=%h prot=%h wdata=%h strb=%h exp all zero",
               pready, pslverr, prdata, bus_valid, bus_write, bus_address, bus_prot,
               bus_write_data, bus_strobe);
    end
    psel = 1'b0; penable = 1'b0; bus_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus_valid !== 1'b0 || pready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got valid=%b pready=%b exp 0 0", bus_valid, pready);
    end
  endtask

  task automatic test_transfers();
    vec_t  vecs[$];
    vec_t  v;
    obs_t  o;
    resp_t e;
    logic [2:0] pr;
    vecs.push_back('{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0, 2});
    vecs.push_back('{1'b0, 16'h0024, 32'h0, 4'h0, 2'b01, 32'h12345678, 1});
    vecs.push_back('{1'b0, 16'h0030, 32'h0, 4'h0, 2'b10, 32'hFFFFFFFF, 0});
    vecs.push_back('{1'b1, 16'h0034, 32'h0BADF00D, 4'h3, 2'b11, 32'h0, 0});
    for (int i = 0; i < 16; i++) begin
      v.wr = 1'($urandom); v.a = AW'($urandom); v.wd = $urandom; v.st = SW'($urandom);
      v.sts = 2'($urandom); v.rd = $urandom; v.w = int'($urandom_range(0, 3));
      vecs.push_back(v);
    end
    foreach (vecs[i]) begin
      v  = vecs[i];
      pr = 3'($urandom);
      e  = model(v.wr, v.st, v.w, v.sts, v.rd);
      apb_xfer(v.wr, v.a, v.wd, v.st, pr, v.w, v.sts, v.rd, 1'b0, 1'b0, o);
      n_tests++;
      if ({o.addr, o.wr, o.prot, o.wdata} !== {v.a, v.wr, pr, v.wd}) begin
        n_fail++;
        $display("FAIL xfer%0d request got a=%h w=%b p=%h d=%h exp a=%h w=%b p=%h d=%h",
                 i, o.addr, o.wr, o.prot, o.wdata, v.a, v.wr, pr, v.wd);
      end
      n_tests++;
      if (o.strobe !== e.strobe) begin
        n_fail++; $display("FAIL xfer%0d bus_strobe got %h exp %h", i, o.strobe, e.strobe);
      end
      n_tests++;
      if (o.stable !== 1'b1 || o.quiet_ok !== 1'b1) begin
        n_fail++;
        $display("FAIL xfer%0d hold got stable=%b quiet=%b exp 1 1", i, o.stable, o.quiet_ok);
      end
      n_tests++;
      if (o.valid_cycles !== e.valid_cycles || o.handshakes !== e.handshakes) begin
        n_fail++;
        $display("FAIL xfer%0d bus_valid got cycles=%0d hs=%0d exp cycles=%0d hs=%0d",
                 i, o.valid_cycles, o.handshakes, e.valid_cycles, e.handshakes);
      end
      n_tests++;
      if (o.ready_cycles !== 1 || o.ack_k !== e.ack_k || o.pready_after !== 1'b0) begin
        n_fail++;
        $display("FAIL xfer%0d pready got n=%0d at=%0d after=%b exp n=1 at=%0d after=0",
                 i, o.ready_cycles, o.ack_k, o.pready_after, e.ack_k);
      end
      n_tests++;
      if (o.prdata !== e.prdata || o.slverr !== e.slverr) begin
        n_fail++;
        $display("FAIL xfer%0d response got prdata=%h slverr=%b exp prdata=%h slverr=%b",
                 i, o.prdata, o.slverr, e.prdata, e.slverr);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o1, o2;
    apb_xfer(1'b1, 16'h0100, 32'h11112222, 4'hF, 3'h0, 0, 2'b00, 32'h0, 1'b0, 1'b1, o1);
    apb_xfer(1'b1, 16'h0104, 32'h33334444, 4'hC, 3'h2, 1, 2'b00, 32'h0, 1'b0, 1'b0, o2);
    n_tests++;
    if (o1.ready_cycles !== 1 || o2.ready_cycles !== 1 ||
        o1.handshakes !== 1 || o2.handshakes !== 1) begin
      n_fail++;
      $display("FAIL b2b_count got pready=%0d,%0d hs=%0d,%0d exp 1,1 1,1",
               o1.ready_cycles, o2.ready_cycles, o1.handshakes, o2.handshakes);
    end
    // One idle/setup cycle between the first pready and the second bus_valid.
    n_tests++;
    if (o2.first_valid_cyc - o1.ack_cyc !== 2) begin
      n_fail++;
      $display("FAIL b2b_gap got %0d exp 2", o2.first_valid_cyc - o1.ack_cyc);
    end
    n_tests++;
    if ({o2.addr, o2.wdata, o2.strobe} !== {16'h0104, 32'h33334444, 4'hC}) begin
      n_fail++;
      $display("FAIL b2b_second got a=%h d=%h s=%h exp a=0104 d=33334444 s=c",
               o2.addr, o2.wdata, o2.strobe);
    end
  endtask

  task automatic test_abort();
    obs_t o;
    apb_xfer(1'b0, 16'h0200, 32'h0, 4'h0, 3'h1, 2, 2'b00, 32'h87654321, 1'b1, 1'b0, o);
    n_tests++;
    if (o.ready_cycles !== 0 || o.handshakes !== 1 || o.valid_cycles !== 3) begin
      n_fail++;
      $display("FAIL abort got pready=%0d hs=%0d valid=%0d exp 0 1 3",
               o.ready_cycles, o.handshakes, o.valid_cycles);
    end
    apb_xfer(1'b0, 16'h0204, 32'h0, 4'h0, 3'h0, 0, 2'b01, 32'h0F0F0F0F, 1'b0, 1'b0, o);
    n_tests++;
    if (o.ready_cycles !== 1 || o.prdata !== 32'h0F0F0F0F || o.slverr !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_next got pready=%0d prdata=%h slverr=%b exp 1 0f0f0f0f 0",
               o.ready_cycles, o.prdata, o.slverr);
    end
  endtask

  // Slave stalls for 12 cycles, then (second access) answers on the 4th BUSY cycle.
  task automatic test_timeout();
    obs_t  o;
    resp_t e;
    e = model(1'b0, 4'h0, 12, 2'b00, 32'hA0A0A0A0);
    apb_xfer(1'b0, 16'h0300, 32'h0, 4'h0, 3'h0, 12, 2'b00, 32'hA0A0A0A0, 1'b0, 1'b0, o);
    n_tests++;
    if (o.valid_cycles !== e.valid_cycles || o.ack_k !== e.ack_k ||
        o.slverr !== e.slverr || o.prdata !== e.prdata) begin
      n_fail++;
      $display("FAIL timeout_long got valid=%0d at=%0d slverr=%b prdata=%h exp %0d %0d %b %h",
               o.valid_cycles, o.ack_k, o.slverr, o.prdata,
               e.valid_cycles, e.ack_k, e.slverr, e.prdata);
    end
    e = model(1'b0, 4'h0, TO - 1, 2'b00, 32'hB1B2B3B4);
    apb_xfer(1'b0, 16'h0304, 32'h0, 4'h0, 3'h0, TO - 1, 2'b00, 32'hB1B2B3B4, 1'b0, 1'b0, o);
    n_tests++;
    if (o.valid_cycles !== e.valid_cycles || o.handshakes !== 1 ||
        o.slverr !== 1'b0 || o.prdata !== 32'hB1B2B3B4) begin
      n_fail++;
      $display("FAIL timeout_edge got valid=%0d hs=%0d slverr=%b prdata=%h exp %0d 1 0 b1b2b3b4",
               o.valid_cycles, o.handshakes, o.slverr, o.prdata, e.valid_cycles);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    bit   quiet;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0040; pprot = 3'h0;
    bus_ready = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus_valid !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_busy got valid=%b exp 1", bus_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus_valid !== 1'b0 || pready !== 1'b0 || bus_address !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_async got valid=%b pready=%b addr=%h exp 0 0 0",
               bus_valid, pready, bus_address);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; bus_ready = 1'b1;
    bus_status = 2'b00; bus_read_data = 32'hDEAD0001;
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (pready !== 1'b0 || bus_valid !== 1'b0) quiet = 1'b0;
    end
    bus_ready = 1'b0;
    n_tests++;
    if (quiet !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_quiet got activity=1 exp 0");
    end
    apb_xfer(1'b0, 16'h0044, 32'h0, 4'h0, 3'h0, 1, 2'b00, 32'h5A5A1234, 1'b0, 1'b0, o);
    n_tests++;
    if (o.ready_cycles !== 1 || o.prdata !== 32'h5A5A1234 || o.slverr !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_fresh got pready=%0d prdata=%h slverr=%b exp 1 5a5a1234 0",
               o.ready_cycles, o.prdata, o.slverr);
    end
  endtask

  initial begin
    test_reset();
    test_transfers();
    test_back_to_back();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
